// File: rtl/fpu_defs.sv
// Shared FPU definitions: operand/command widths, flag bit positions and the
// result record carried from the shared FPU back to the issuing core.
package fpu_defs;

    localparam int unsigned C_OP   = 32;
    localparam int unsigned C_CMD  = 6;
    localparam int unsigned C_RM   = 3;
    localparam int unsigned C_TAG  = 2;
    localparam int unsigned C_FLAG = 9;

    // Flag vector layout, MSB first: {0, Inf, IV, IX, Zero, 0, 0, UF, OF}
    localparam int unsigned F_OF   = 0;
    localparam int unsigned F_UF   = 1;
    localparam int unsigned F_ZERO = 4;
    localparam int unsigned F_IX   = 5;
    localparam int unsigned F_IV   = 6;
    localparam int unsigned F_INF  = 7;

    // One returned result as it sits in the dispatcher's result buffer
    typedef struct packed {
        logic [C_OP-1:0]   result;
        logic [C_FLAG-1:0] flags;
        logic [C_TAG-1:0]  tag;
    } apu_res_t;

endpackage

// File: rtl/marx_apu_if.sv
// Cluster APU link between a core-side dispatcher (master) and the shared
// FPU responder (slave). Downstream: valid/ready op issue. Upstream: req/ack
// result return.
interface marx_apu_if
    import fpu_defs::*;
();

    logic              valid_ds_s;
    logic              ready_ds_s;
    logic [C_OP-1:0]   arga_ds_d;
    logic [C_OP-1:0]   argb_ds_d;
    logic [C_CMD-1:0]  op_ds_d;
    logic [C_RM-1:0]   flags_ds_d;
    logic [C_TAG-1:0]  tag_ds_d;

    logic              req_us_s;
    logic              ack_us_s;
    logic [C_OP-1:0]   result_us_d;
    logic [C_FLAG-1:0] flags_us_d;
    logic [C_TAG-1:0]  tag_us_d;

    modport master (
        output valid_ds_s, arga_ds_d, argb_ds_d, op_ds_d, flags_ds_d, tag_ds_d, ack_us_s,
        input  ready_ds_s, req_us_s, result_us_d, flags_us_d, tag_us_d
    );

    modport slave (
        input  valid_ds_s, arga_ds_d, argb_ds_d, op_ds_d, flags_ds_d, tag_ds_d, ack_us_s,
        output ready_ds_s, req_us_s, result_us_d, flags_us_d, tag_us_d
    );

endinterface

// File: rtl/apu_res_fifo.sv
// Small registered FIFO of returned APU results. The head is always read from
// storage (no fall-through), so a pushed entry becomes visible one cycle later.
// Push while full and pop while empty are ignored.
module apu_res_fifo
    import fpu_defs::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     Clk_CI,
    input  logic     Rst_RBI,
    input  logic     push_si,
    input  apu_res_t push_data_di,
    input  logic     pop_si,
    output apu_res_t head_do,
    output logic     full_so,
    output logic     empty_so
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    apu_res_t         mem_q [DEPTH];
    apu_res_t         mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_so  = (cnt_q == DEPTH_CNT);
    assign empty_so = (cnt_q == '0);
    assign do_push  = push_si & ~full_so;
    assign do_pop   = pop_si & ~empty_so;
    assign head_do  = mem_q[rd_ptr_q];

    // Next storage, pointers (wrapping at DEPTH, not a power of two) and fill count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_di;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/apu_dispatcher.sv
// Core-side APU dispatcher: issues FP ops to the shared FPU under a free tag,
// remembers each tag's destination register, buffers returned results and
// hands them to register-file writeback. NUM_TAGS must not exceed 2**C_TAG.
module apu_dispatcher
    import fpu_defs::*;
#(
    parameter int unsigned NUM_TAGS  = 4,
    parameter int unsigned RES_DEPTH = 2,
    parameter int unsigned C_RD      = 5
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Req_SI,
    output logic              Gnt_SO,
    input  logic [C_OP-1:0]   OpA_DI,
    input  logic [C_OP-1:0]   OpB_DI,
    input  logic [C_CMD-1:0]  Op_SI,
    input  logic [C_RM-1:0]   RM_SI,
    input  logic [C_RD-1:0]   Rd_DI,
    output logic              WbValid_SO,
    input  logic              WbReady_SI,
    output logic [C_OP-1:0]   WbResult_DO,
    output logic [C_FLAG-1:0] WbFlags_SO,
    output logic [C_RD-1:0]   WbRd_DO,
    output logic              Busy_SO,
    output logic              TagErr_SO,
    marx_apu_if.master        apu
);

    logic [NUM_TAGS-1:0] alloc_q, alloc_d;
    logic [C_RD-1:0]     rd_q [NUM_TAGS];
    logic [C_RD-1:0]     rd_d [NUM_TAGS];
    logic                tag_err_q, tag_err_d;

    logic                tag_avail;
    logic [C_TAG-1:0]    free_tag;
    logic                gnt;
    logic                ack;
    logic                push;
    logic                pop;
    logic                push_tag_alloc;
    logic [C_RD-1:0]     head_rd;
    logic                fifo_full;
    logic                fifo_empty;
    apu_res_t            push_data;
    apu_res_t            head;

    // Lowest-index free tag, searched on the registered table only so a tag
    // freed this cycle cannot be handed out again until the next one
    always_comb begin
        tag_avail = 1'b0;
        free_tag  = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                tag_avail = 1'b1;
                free_tag  = C_TAG'(i);
            end
        end
    end

    assign apu.valid_ds_s = Req_SI & tag_avail;
    assign apu.arga_ds_d  = OpA_DI;
    assign apu.argb_ds_d  = OpB_DI;
    assign apu.op_ds_d    = Op_SI;
    assign apu.flags_ds_d = RM_SI;
    assign apu.tag_ds_d   = free_tag;
    assign gnt            = Req_SI & tag_avail & apu.ready_ds_s;
    assign Gnt_SO         = gnt;

    assign ack            = ~fifo_full;
    assign apu.ack_us_s   = ack;
    assign push           = apu.req_us_s & ack;
    assign push_data      = '{result: apu.result_us_d, flags: apu.flags_us_d, tag: apu.tag_us_d};

    assign pop            = ~fifo_empty & WbReady_SI;
    assign WbValid_SO     = ~fifo_empty;
    assign WbResult_DO    = head.result;
    assign WbFlags_SO     = head.flags;
    assign WbRd_DO        = head_rd;
    assign Busy_SO        = (|alloc_q) | ~fifo_empty;
    assign TagErr_SO      = tag_err_q;

    // Table lookups for the incoming result's tag and the FIFO head's tag;
    // tag values beyond the table read as unallocated with no register
    always_comb begin
        push_tag_alloc = 1'b0;
        head_rd        = '0;
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            if (apu.tag_us_d == C_TAG'(i)) begin
                push_tag_alloc = alloc_q[i];
            end
            if (head.tag == C_TAG'(i)) begin
                head_rd = rd_q[i];
            end
        end
    end

    // Tag table update: writeback frees the head's tag, a grant claims the
    // free tag; the claim is ordered last so it wins if both hit one entry
    always_comb begin
        alloc_d   = alloc_q;
        rd_d      = rd_q;
        tag_err_d = tag_err_q | (push & ~push_tag_alloc);
        for (int i = 0; i < int'(NUM_TAGS); i++) begin
            if (pop && (head.tag == C_TAG'(i))) begin
                alloc_d[i] = 1'b0;
            end
            if (gnt && (free_tag == C_TAG'(i))) begin
                alloc_d[i] = 1'b1;
                rd_d[i]    = Rd_DI;
            end
        end
    end

    // Tag table and sticky error registers
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            alloc_q   <= '0;
            tag_err_q <= 1'b0;
            for (int i = 0; i < int'(NUM_TAGS); i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            alloc_q   <= alloc_d;
            rd_q      <= rd_d;
            tag_err_q <= tag_err_d;
        end
    end

    apu_res_fifo #(
        .DEPTH (RES_DEPTH)
    ) i_res_fifo (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .push_si      (push),
        .push_data_di (push_data),
        .pop_si       (pop),
        .head_do      (head),
        .full_so      (fifo_full),
        .empty_so     (fifo_empty)
    );

endmodule

// File: tb/tb_apu_dispatcher.sv
// Self-checking bench for apu_dispatcher: directed scenarios plus a random
// phase, all compared against a tag-table/queue reference model.
module tb_apu_dispatcher;
    import fpu_defs::*;

    localparam int NT    = 4;
    localparam int DEPTH = 2;
    localparam int RDW   = 5;

    logic              Clk_CI = 1'b0;
    logic              Rst_RBI;
    logic              Req_SI;
    logic              Gnt_SO;
    logic [C_OP-1:0]   OpA_DI;
    logic [C_OP-1:0]   OpB_DI;
    logic [C_CMD-1:0]  Op_SI;
    logic [C_RM-1:0]   RM_SI;
    logic [RDW-1:0]    Rd_DI;
    logic              WbValid_SO;
    logic              WbReady_SI;
    logic [C_OP-1:0]   WbResult_DO;
    logic [C_FLAG-1:0] WbFlags_SO;
    logic [RDW-1:0]    WbRd_DO;
    logic              Busy_SO;
    logic              TagErr_SO;

    marx_apu_if apu ();

    apu_dispatcher #(
        .NUM_TAGS  (NT),
        .RES_DEPTH (DEPTH),
        .C_RD      (RDW)
    ) dut (
        .Clk_CI      (Clk_CI),
        .Rst_RBI     (Rst_RBI),
        .Req_SI      (Req_SI),
        .Gnt_SO      (Gnt_SO),
        .OpA_DI      (OpA_DI),
        .OpB_DI      (OpB_DI),
        .Op_SI       (Op_SI),
        .RM_SI       (RM_SI),
        .Rd_DI       (Rd_DI),
        .WbValid_SO  (WbValid_SO),
        .WbReady_SI  (WbReady_SI),
        .WbResult_DO (WbResult_DO),
        .WbFlags_SO  (WbFlags_SO),
        .WbRd_DO     (WbRd_DO),
        .Busy_SO     (Busy_SO),
        .TagErr_SO   (TagErr_SO),
        .apu         (apu)
    );

    always #5 Clk_CI = ~Clk_CI;

    // Reference model: which tags are in flight with their register, the
    // ordered list of buffered results, and the sticky error bit
    bit             m_alloc [NT];
    logic [RDW-1:0] m_rd    [NT];
    apu_res_t       m_q     [$];
    bit             m_err;

    // Responder model: granted-but-not-returned tags, and the one result
    // currently being offered upstream
    int                pend [$];
    bit                resp_active;
    logic [C_TAG-1:0]  resp_tag;
    logic [C_OP-1:0]   resp_res;
    logic [C_FLAG-1:0] resp_flags;

    int checks;
    int errors;

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic driveResp();
        apu.req_us_s    = resp_active;
        apu.tag_us_d    = resp_tag;
        apu.result_us_d = resp_res;
        apu.flags_us_d  = resp_flags;
    endtask

    task automatic startReturn(input int t, input logic [C_OP-1:0] res, input logic [C_FLAG-1:0] fl);
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i] == t) begin
                pend.delete(i);
                break;
            end
        end
        resp_active = 1'b1;
        resp_tag    = C_TAG'(t);
        resp_res    = res;
        resp_flags  = fl;
        driveResp();
    endtask

    task automatic modelReset();
        for (int i = 0; i < NT; i++) begin
            m_alloc[i] = 1'b0;
            m_rd[i]    = '0;
        end
        m_q.delete();
        pend.delete();
        m_err       = 1'b0;
        resp_active = 1'b0;
    endtask

    // Compare every DUT output with the model for this cycle, then clock once
    // and advance the model by the handshakes that happened at the edge
    task automatic applyStimulus();
        bit       any_free;
        int       ftag;
        bit       e_valid, e_gnt, e_ack, e_wbv, e_busy, push, pop, push_err;
        apu_res_t head, ent;
        driveResp();
        #1;
        any_free = 1'b0;
        ftag     = 0;
        e_busy   = (m_q.size() > 0);
        for (int i = 0; i < NT; i++) begin
            if (!m_alloc[i] && !any_free) begin
                any_free = 1'b1;
                ftag     = i;
            end
            if (m_alloc[i]) e_busy = 1'b1;
        end
        e_valid = Req_SI & any_free;
        e_gnt   = e_valid & apu.ready_ds_s;
        e_ack   = (m_q.size() < DEPTH);
        e_wbv   = (m_q.size() > 0);
        checkOutput("valid_ds", 64'(apu.valid_ds_s), 64'(e_valid));
        checkOutput("gnt", 64'(Gnt_SO), 64'(e_gnt));
        checkOutput("ack_us", 64'(apu.ack_us_s), 64'(e_ack));
        checkOutput("wbvalid", 64'(WbValid_SO), 64'(e_wbv));
        checkOutput("busy", 64'(Busy_SO), 64'(e_busy));
        checkOutput("tagerr", 64'(TagErr_SO), 64'(m_err));
        checkOutput("arga", 64'(apu.arga_ds_d), 64'(OpA_DI));
        checkOutput("argb", 64'(apu.argb_ds_d), 64'(OpB_DI));
        checkOutput("op", 64'(apu.op_ds_d), 64'(Op_SI));
        checkOutput("rm", 64'(apu.flags_ds_d), 64'(RM_SI));
        if (any_free) checkOutput("tag_ds", 64'(apu.tag_ds_d), 64'(ftag));
        head = '0;
        if (e_wbv) begin
            head = m_q[0];
            checkOutput("wbresult", 64'(WbResult_DO), 64'(head.result));
            checkOutput("wbflags", 64'(WbFlags_SO), 64'(head.flags));
            checkOutput("wbrd", 64'(WbRd_DO), 64'(m_rd[head.tag]));
        end
        pop      = e_wbv & WbReady_SI;
        push     = resp_active & e_ack;
        push_err = push & !m_alloc[resp_tag];
        @(posedge Clk_CI);
        if (pop) begin
            m_alloc[head.tag] = 1'b0;
            void'(m_q.pop_front());
        end
        if (e_gnt) begin
            m_alloc[ftag] = 1'b1;
            m_rd[ftag]    = Rd_DI;
            pend.push_back(ftag);
        end
        if (push) begin
            ent.result  = resp_res;
            ent.flags   = resp_flags;
            ent.tag     = resp_tag;
            m_q.push_back(ent);
            resp_active = 1'b0;
            if (push_err) m_err = 1'b1;
        end
        #1;
        driveResp();
    endtask

    task automatic setIdle();
        Req_SI         = 1'b0;
        WbReady_SI     = 1'b0;
        apu.ready_ds_s = 1'b1;
    endtask

    // One randomized cycle: percentages for core request, FPU ready,
    // writeback ready and the responder starting a return
    task automatic autoCycle(input int reqPct, input int rdyPct, input int wbPct, input int respPct);
        int idx;
        Req_SI         = ($urandom_range(0, 99) < reqPct);
        OpA_DI         = $urandom;
        OpB_DI         = $urandom;
        Op_SI          = C_CMD'($urandom);
        RM_SI          = C_RM'($urandom);
        Rd_DI          = RDW'($urandom);
        apu.ready_ds_s = ($urandom_range(0, 99) < rdyPct);
        WbReady_SI     = ($urandom_range(0, 99) < wbPct);
        if (!resp_active && pend.size() > 0 && $urandom_range(0, 99) < respPct) begin
            idx = $urandom_range(0, pend.size() - 1);
            startReturn(pend[idx], $urandom, C_FLAG'($urandom));
        end
        applyStimulus();
    endtask

    task automatic drainAll();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            autoCycle(0, 100, 100, 100);
            done = (m_q.size() == 0) && !resp_active && (pend.size() == 0);
            for (int i = 0; i < NT; i++) if (m_alloc[i]) done = 1'b0;
        end
        checkOutput("drain_done", 64'(done), 64'(1));
        setIdle();
    endtask

    task automatic issue(input logic [RDW-1:0] rd, input int expTag);
        Req_SI = 1'b1;
        Rd_DI  = rd;
        OpA_DI = 32'h1000 + 32'(rd);
        #1;
        checkOutput("issue_gnt", 64'(Gnt_SO), 64'(1));
        checkOutput("issue_tag", 64'(apu.tag_ds_d), 64'(expTag));
        applyStimulus();
        Req_SI = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [C_OP-1:0] bp_res [3];
        int k;

        checks  = 0;
        errors  = 0;
        Rst_RBI = 1'b0;
        Req_SI  = 1'b1;
        OpA_DI  = '0;
        OpB_DI  = '0;
        Op_SI   = '0;
        RM_SI   = '0;
        Rd_DI   = '0;
        WbReady_SI     = 1'b0;
        apu.ready_ds_s = 1'b0;
        modelReset();
        driveResp();
        repeat (2) @(posedge Clk_CI);
        #1;
        checkOutput("rst_gnt", 64'(Gnt_SO), 64'(0));
        checkOutput("rst_valid", 64'(apu.valid_ds_s), 64'(1));
        checkOutput("rst_tag", 64'(apu.tag_ds_d), 64'(0));
        checkOutput("rst_ack", 64'(apu.ack_us_s), 64'(1));
        checkOutput("rst_wbvalid", 64'(WbValid_SO), 64'(0));
        checkOutput("rst_busy", 64'(Busy_SO), 64'(0));
        checkOutput("rst_tagerr", 64'(TagErr_SO), 64'(0));
        Rst_RBI = 1'b1;
        setIdle();
        @(posedge Clk_CI);
        #1;

        $display("[TB] single op");
        Req_SI = 1'b1;
        OpA_DI = 32'h3F80_0000;
        OpB_DI = 32'h4000_0000;
        Op_SI  = 6'd1;
        Rd_DI  = 5'd7;
        #1;
        checkOutput("t1_gnt", 64'(Gnt_SO), 64'(1));
        checkOutput("t1_tag", 64'(apu.tag_ds_d), 64'(0));
        applyStimulus();
        Req_SI = 1'b0;
        applyStimulus();
        applyStimulus();
        startReturn(0, 32'h4040_0000, C_FLAG'(1 << F_IX));
        applyStimulus();
        #1;
        checkOutput("t1_wbvalid", 64'(WbValid_SO), 64'(1));
        checkOutput("t1_wbresult", 64'(WbResult_DO), 64'h4040_0000);
        checkOutput("t1_wbflags", 64'(WbFlags_SO), 64'h20);
        checkOutput("t1_wbrd", 64'(WbRd_DO), 64'(7));
        WbReady_SI = 1'b1;
        applyStimulus();
        WbReady_SI = 1'b0;
        #1;
        checkOutput("t1_busy", 64'(Busy_SO), 64'(0));
        applyStimulus();

        $display("[TB] tag exhaustion");
        for (int i = 0; i < NT; i++) issue(RDW'(i + 1), i);
        Req_SI = 1'b1;
        Rd_DI  = 5'd20;
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("t2_full_valid", 64'(apu.valid_ds_s), 64'(0));
            checkOutput("t2_full_gnt", 64'(Gnt_SO), 64'(0));
            applyStimulus();
        end
        WbReady_SI = 1'b1;
        startReturn(1, 32'h1111_1111, '0);
        applyStimulus();
        #1;
        checkOutput("t2_pop_gnt", 64'(Gnt_SO), 64'(0));
        applyStimulus();
        #1;
        checkOutput("t2_regnt", 64'(Gnt_SO), 64'(1));
        checkOutput("t2_regnt_tag", 64'(apu.tag_ds_d), 64'(1));
        applyStimulus();
        Req_SI = 1'b0;
        drainAll();

        $display("[TB] out-of-order return");
        issue(5'd3, 0);
        issue(5'd9, 1);
        startReturn(1, 32'hB1, '0);
        applyStimulus();
        startReturn(0, 32'hB0, '0);
        applyStimulus();
        WbReady_SI = 1'b1;
        #1;
        checkOutput("t3_first_rd", 64'(WbRd_DO), 64'(9));
        applyStimulus();
        #1;
        checkOutput("t3_second_rd", 64'(WbRd_DO), 64'(3));
        applyStimulus();
        drainAll();

        $display("[TB] backpressure");
        issue(5'd10, 0);
        issue(5'd11, 1);
        issue(5'd12, 2);
        bp_res[0] = 32'hA0;
        bp_res[1] = 32'hA1;
        bp_res[2] = 32'hA2;
        startReturn(0, bp_res[0], '0);
        applyStimulus();
        startReturn(1, bp_res[1], '0);
        applyStimulus();
        startReturn(2, bp_res[2], '0);
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("t4_ack_held", 64'(apu.ack_us_s), 64'(0));
            applyStimulus();
        end
        WbReady_SI = 1'b1;
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            #1;
            if (WbValid_SO) begin
                checkOutput("t4_drain_res", 64'(WbResult_DO), 64'(bp_res[k]));
                checkOutput("t4_drain_rd", 64'(WbRd_DO), 64'(10 + k));
                k++;
            end
            applyStimulus();
        end
        checkOutput("t4_drain_count", 64'(k), 64'(3));
        #1;
        checkOutput("t4_empty", 64'(WbValid_SO), 64'(0));
        drainAll();

        $display("[TB] simultaneous free and allocate");
        for (int i = 0; i < NT; i++) issue(RDW'(i + 1), i);
        startReturn(2, 32'hC2, '0);
        applyStimulus();
        Req_SI     = 1'b1;
        Rd_DI      = 5'd15;
        WbReady_SI = 1'b1;
        #1;
        checkOutput("t5_same_gnt", 64'(Gnt_SO), 64'(0));
        checkOutput("t5_same_wbv", 64'(WbValid_SO), 64'(1));
        applyStimulus();
        #1;
        checkOutput("t5_next_gnt", 64'(Gnt_SO), 64'(1));
        checkOutput("t5_next_tag", 64'(apu.tag_ds_d), 64'(2));
        applyStimulus();
        Req_SI = 1'b0;
        drainAll();

        $display("[TB] unallocated tag and reset");
        startReturn(3, 32'hDEAD, '0);
        applyStimulus();
        #1;
        checkOutput("t6_tagerr", 64'(TagErr_SO), 64'(1));
        WbReady_SI = 1'b1;
        applyStimulus();
        WbReady_SI = 1'b0;
        #1;
        checkOutput("t6_tagerr_sticky", 64'(TagErr_SO), 64'(1));
        issue(5'd5, 0);
        startReturn(0, 32'hE0, '0);
        applyStimulus();
        Req_SI         = 1'b1;
        apu.ready_ds_s = 1'b0;
        Rst_RBI        = 1'b0;
        modelReset();
        driveResp();
        #1;
        checkOutput("t6_rst_gnt", 64'(Gnt_SO), 64'(0));
        checkOutput("t6_rst_valid", 64'(apu.valid_ds_s), 64'(1));
        checkOutput("t6_rst_tag", 64'(apu.tag_ds_d), 64'(0));
        checkOutput("t6_rst_ack", 64'(apu.ack_us_s), 64'(1));
        checkOutput("t6_rst_wbvalid", 64'(WbValid_SO), 64'(0));
        checkOutput("t6_rst_busy", 64'(Busy_SO), 64'(0));
        checkOutput("t6_rst_tagerr", 64'(TagErr_SO), 64'(0));
        @(posedge Clk_CI);
        #1;
        Rst_RBI = 1'b1;
        setIdle();
        applyStimulus();

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) autoCycle(70, 80, 60, 40);
        drainAll();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
